// File: rtl/ifetch_responder.sv
// ifetch_responder: fetch-side responder with a one-entry (pc,inst) buffer over a req/ack instruction bus
module ifetch_responder #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter int              MAX_WAIT = 16,
   parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] inst_o,
   output logic              inst_valid_o,
   output logic              stall_req_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   localparam int CW = $clog2(MAX_WAIT);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t            state;
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_pc;
   logic [DATA_W-1:0] buf_inst;
   logic [ADDR_W-1:0] req_pc;
   logic [CW-1:0]     cnt;
   logic              hit, mis, last;
   assign hit        = buf_valid && (pc_i == buf_pc);
   assign mis        = ce_i && (pc_i[1:0] != 2'b00);
   assign last       = (cnt == CW'(MAX_WAIT - 1));
   assign misalign_o = mis;
   // serve the fetch unit straight from the buffer; anything not yet served stalls
   always_comb begin
      inst_o       = NOP_INST;
      inst_valid_o = 1'b0;
      stall_req_o  = 1'b0;
      if (ce_i) begin
         inst_valid_o = mis || (hit && state == IDLE);
         stall_req_o  = !inst_valid_o;
         inst_o       = (!mis && hit && state == IDLE) ? buf_inst : NOP_INST;
      end
   end
   // bus fetch FSM: issue on miss, fill on ack, drain an unabortable request after flush
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state      <= IDLE;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         buf_valid  <= 1'b0;
         buf_pc     <= '0;
         buf_inst   <= NOP_INST;
         bus_err_o  <= 1'b0;
         req_pc     <= '0;
         cnt        <= '0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_i) begin
                  buf_valid <= 1'b0;
               end else if (ce_i && !mis && !hit) begin
                  state      <= WAIT;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {pc_i[ADDR_W-1:2], 2'b00};
                  req_pc     <= pc_i;
                  cnt        <= '0;
               end
            end
            WAIT: begin
               cnt <= last ? cnt : cnt + 1'b1;
               if (flush_i) begin
                  buf_valid <= 1'b0;
                  if (mem_ack_i) begin
                     mem_req_o <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (mem_ack_i) begin
                  buf_inst  <= mem_rdata_i;
                  buf_pc    <= req_pc;
                  buf_valid <= 1'b1;
                  mem_req_o <= 1'b0;
                  state     <= IDLE;
               end else if (last) begin
                  buf_inst  <= NOP_INST;
                  buf_pc    <= req_pc;
                  buf_valid <= 1'b1;
                  bus_err_o <= 1'b1;
                  mem_req_o <= 1'b0;
                  state     <= IDLE;
               end
            end
            DRAIN: begin
               cnt <= last ? cnt : cnt + 1'b1;
               if (mem_ack_i || last) begin
                  mem_req_o <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder: directed checks of the fetch responder
module tb_ifetch_responder;
   logic        clk_i = 1'b0;
   logic        n_rst_i;
   logic [31:0] pc_i;
   logic        ce_i, flush_i, mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] inst_o, mem_addr_o;
   logic        inst_valid_o, stall_req_o, misalign_o, bus_err_o, mem_req_o;
   int          checks = 0;
   int          errors = 0;
   localparam logic [31:0] NOP = 32'h00000013;

   ifetch_responder dut (
      .clk_i(clk_i), .n_rst_i(n_rst_i), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
      .inst_o(inst_o), .inst_valid_o(inst_valid_o), .stall_req_o(stall_req_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      n_rst_i = 1'b0; pc_i = '0; ce_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
      #7;
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_stall", 32'(stall_req_o), 32'd0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      #1 n_rst_i = 1'b1;
      tick();
      // 1: miss at 0x100, ack two cycles after the request
      ce_i = 1'b1; pc_i = 32'h100; #1;
      chk("t1_stall0", 32'(stall_req_o), 32'd1);
      chk("t1_req0", 32'(mem_req_o), 32'd0);
      tick();
      chk("t1_req1", 32'(mem_req_o), 32'd1);
      chk("t1_addr", mem_addr_o, 32'h100);
      chk("t1_stall1", 32'(stall_req_o), 32'd1);
      tick();
      chk("t1_stall2", 32'(stall_req_o), 32'd1);
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
      chk("t1_stall3", 32'(stall_req_o), 32'd1);
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
      chk("t1_valid", 32'(inst_valid_o), 32'd1);
      chk("t1_inst", inst_o, 32'hDEADBEEF);
      chk("t1_stall4", 32'(stall_req_o), 32'd0);
      chk("t1_reqoff", 32'(mem_req_o), 32'd0);
      // 2: held PC hits for five more cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_req", 32'(mem_req_o), 32'd0);
         chk("t2_valid", 32'(inst_valid_o), 32'd1);
         chk("t2_stall", 32'(stall_req_o), 32'd0);
         chk("t2_inst", inst_o, 32'hDEADBEEF);
      end
      // 3: misaligned PC returns NOP without a bus access
      pc_i = 32'h102; #1;
      chk("t3_mis", 32'(misalign_o), 32'd1);
      chk("t3_inst", inst_o, NOP);
      chk("t3_valid", 32'(inst_valid_o), 32'd1);
      chk("t3_stall", 32'(stall_req_o), 32'd0);
      tick();
      chk("t3_req", 32'(mem_req_o), 32'd0);
      ce_i = 1'b0; #1;
      chk("t3_mis_noce", 32'(misalign_o), 32'd0);
      chk("t3_valid_noce", 32'(inst_valid_o), 32'd0);
      tick();
      // 4: flush before ack, drain, then refetch at 0x300
      ce_i = 1'b1; pc_i = 32'h200; #1;
      chk("t4_stallA", 32'(stall_req_o), 32'd1);
      tick();
      chk("t4_reqB", 32'(mem_req_o), 32'd1);
      chk("t4_addrB", mem_addr_o, 32'h200);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; pc_i = 32'h300; #1;
      chk("t4_stallC", 32'(stall_req_o), 32'd1);
      chk("t4_reqC", 32'(mem_req_o), 32'd1);
      chk("t4_addrC", mem_addr_o, 32'h200);
      tick();
      chk("t4_stallD", 32'(stall_req_o), 32'd1);
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA5555; #1;
      chk("t4_stallE", 32'(stall_req_o), 32'd1);
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
      chk("t4_reqF", 32'(mem_req_o), 32'd0);
      chk("t4_stallF", 32'(stall_req_o), 32'd1);
      chk("t4_validF", 32'(inst_valid_o), 32'd0);
      tick();
      chk("t4_req300", 32'(mem_req_o), 32'd1);
      chk("t4_addr300", mem_addr_o, 32'h300);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
      chk("t4_inst300", inst_o, 32'h11111111);
      chk("t4_valid300", 32'(inst_valid_o), 32'd1);
      pc_i = 32'h200; #1;
      chk("t4_nohit200", 32'(inst_valid_o), 32'd0);
      ce_i = 1'b0;
      tick();
      // 5: no ack, timeout after 16 WAIT cycles
      ce_i = 1'b1; pc_i = 32'h400; #1;
      chk("t5_stall0", 32'(stall_req_o), 32'd1);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t5_req", 32'(mem_req_o), 32'd1);
         chk("t5_noerr", 32'(bus_err_o), 32'd0);
         chk("t5_stall", 32'(stall_req_o), 32'd1);
         tick();
      end
      chk("t5_reqoff", 32'(mem_req_o), 32'd0);
      chk("t5_err", 32'(bus_err_o), 32'd1);
      chk("t5_valid", 32'(inst_valid_o), 32'd1);
      chk("t5_inst", inst_o, NOP);
      chk("t5_stalloff", 32'(stall_req_o), 32'd0);
      tick();
      chk("t5_errpulse", 32'(bus_err_o), 32'd0);
      chk("t5_valid2", 32'(inst_valid_o), 32'd1);
      // 6: async reset mid-WAIT, late ack ignored
      pc_i = 32'h500;
      tick();
      chk("t6_req", 32'(mem_req_o), 32'd1);
      #2 n_rst_i = 1'b0; #1;
      chk("t6_reqrst", 32'(mem_req_o), 32'd0);
      chk("t6_validrst", 32'(inst_valid_o), 32'd0);
      ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h00000BAD;
      #1 n_rst_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = '0; ce_i = 1'b1; #1;
      chk("t6_lateack", 32'(inst_valid_o), 32'd0);
      chk("t6_reqidle", 32'(mem_req_o), 32'd0);
      // flush together with ack discards the data and returns to IDLE
      tick();
      chk("t7_req", 32'(mem_req_o), 32'd1);
      flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
      tick();
      flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
      chk("t7_reqoff", 32'(mem_req_o), 32'd0);
      chk("t7_valid", 32'(inst_valid_o), 32'd0);
      ce_i = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
